// File: rtl/sb_seven_seg.sv
// Registered hex/BCD to seven-segment decoder for one display digit.
// Segment, decimal-point and digit-enable polarity are fixed by parameters ahead of the output flops.
module sb_seven_seg #(
   parameter bit SEG_ACTIVE_LOW   = 1'b0,
   parameter bit DIGIT_ACTIVE_LOW = 1'b0,
   parameter bit BCD_ONLY         = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic w,
   input  logic x,
   input  logic y,
   input  logic z,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g,
   output logic dp,
   output logic digit
);

   logic [3:0] code;
   logic [6:0] seg_lit;
   logic [6:0] seg_phys;

   assign code = {w, x, y, z};

   // Logical lit pattern, bit order a..g from MSB to LSB
   always_comb begin
      seg_lit = '0;
      case (code)
         4'h0: seg_lit = 7'b1111110;
         4'h1: seg_lit = 7'b0110000;
         4'h2: seg_lit = 7'b1101101;
         4'h3: seg_lit = 7'b1111001;
         4'h4: seg_lit = 7'b0110011;
         4'h5: seg_lit = 7'b1011011;
         4'h6: seg_lit = 7'b1011111;
         4'h7: seg_lit = 7'b1110000;
         4'h8: seg_lit = 7'b1111111;
         4'h9: seg_lit = 7'b1111011;
         4'hA: seg_lit = 7'b1110111;
         4'hB: seg_lit = 7'b0011111;
         4'hC: seg_lit = 7'b1001110;
         4'hD: seg_lit = 7'b0111101;
         4'hE: seg_lit = 7'b1001111;
         4'hF: seg_lit = 7'b1000111;
         default: seg_lit = '0;
      endcase
      if (BCD_ONLY && (code > 4'd9)) begin
         seg_lit = '0;
      end
   end

   always_comb begin
      seg_phys = seg_lit ^ {7{SEG_ACTIVE_LOW}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {a, b, c, d, e, f, g} <= {7{SEG_ACTIVE_LOW}};
         dp                    <= SEG_ACTIVE_LOW;
         digit                 <= DIGIT_ACTIVE_LOW;
      end else begin
         {a, b, c, d, e, f, g} <= seg_phys;
         dp                    <= SEG_ACTIVE_LOW;
         digit                 <= ~DIGIT_ACTIVE_LOW;
      end
   end

endmodule

// File: tb/tb_sb_seven_seg.sv
// Scoreboard bench for sb_seven_seg: three parameter variants share one stimulus stream.
// The stimulus pushes each issued {rst, code} into a queue; the monitor pops one per edge and checks.
module tb_sb_seven_seg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;

   logic [8:0] out_hex, out_bcd, out_low;

   typedef struct {
      logic       r;
      logic [3:0] code;
   } stim_t;

   stim_t sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [6:0] TAB [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   always #5 clk = ~clk;

   sb_seven_seg #(.SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0), .BCD_ONLY(1'b0)) u_hex (
      .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
      .a(out_hex[8]), .b(out_hex[7]), .c(out_hex[6]), .d(out_hex[5]), .e(out_hex[4]),
      .f(out_hex[3]), .g(out_hex[2]), .dp(out_hex[1]), .digit(out_hex[0])
   );

   sb_seven_seg #(.SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0), .BCD_ONLY(1'b1)) u_bcd (
      .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
      .a(out_bcd[8]), .b(out_bcd[7]), .c(out_bcd[6]), .d(out_bcd[5]), .e(out_bcd[4]),
      .f(out_bcd[3]), .g(out_bcd[2]), .dp(out_bcd[1]), .digit(out_bcd[0])
   );

   sb_seven_seg #(.SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1), .BCD_ONLY(1'b0)) u_low (
      .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
      .a(out_low[8]), .b(out_low[7]), .c(out_low[6]), .d(out_low[5]), .e(out_low[4]),
      .f(out_low[3]), .g(out_low[2]), .dp(out_low[1]), .digit(out_low[0])
   );

   // Expected physical pins {a..g, dp, digit} from the decode rules
   function automatic logic [8:0] model(input logic r, input logic [3:0] code,
                                        input bit bcd, input bit seg_low, input bit dig_low);
      logic [6:0] seg;
      logic       en;
      seg = TAB[code];
      if (r || (bcd && code >= 4'd10)) seg = 7'b0000000;
      en = !r;
      return {seg ^ {7{seg_low}}, seg_low, en ^ dig_low};
   endfunction

   task automatic check(input string name, input stim_t s, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s rst=%0b code=%0h: got %b (a..g,dp,digit) expected %b",
                  name, s.r, s.code, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] code);
      stim_t s;
      @(negedge clk);
      rst = r;
      {w, x, y, z} = code;
      s.r = r;
      s.code = code;
      sb_q.push_back(s);
   endtask

   // Monitor: outputs are presented every edge; one queued stimulus per edge
   initial begin
      stim_t s;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            check("hex", s, out_hex, model(s.r, s.code, 1'b0, 1'b0, 1'b0));
            check("bcd", s, out_bcd, model(s.r, s.code, 1'b1, 1'b0, 1'b0));
            check("low", s, out_low, model(s.r, s.code, 1'b0, 1'b1, 1'b1));
         end
      end
   end

   initial begin
      // reset with code 8, then release
      drive(1'b1, 4'd8);
      drive(1'b1, 4'd8);
      drive(1'b0, 4'd8);
      // full sweep
      for (int unsigned i = 0; i < 16; i++) drive(1'b0, 4'(i));
      // binary counter: z/y/x/w toggle at 1x/2x/4x/8x
      for (int unsigned i = 0; i < 32; i++) drive(1'b0, 4'(i));
      // mid-run reset with code 5
      drive(1'b0, 4'd5);
      drive(1'b0, 4'd5);
      drive(1'b1, 4'd5);
      drive(1'b0, 4'd5);
      // BCD boundary and active-low code 0
      drive(1'b0, 4'd12);
      drive(1'b0, 4'd9);
      drive(1'b0, 4'd10);
      drive(1'b0, 4'd0);
      // random traffic with occasional reset
      for (int unsigned i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
      end
      repeat (3) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sb_seven_seg.md
Name: sb_seven_seg

Overview:
Registered hex-to-seven-segment decoder for a single display digit. It takes a 4-bit code on the discrete inputs w (MSB), x, y, z (LSB) and drives segments a–g, a decimal point dp and a digit-enable, all registered on one clock. It sits between the 4-bit value source (switches or counter) and the board's display pins.

Parameters:
SEG_ACTIVE_LOW, 0, 1 inverts a–g and dp at the output register (lit = 0); 0 means lit = 1.
DIGIT_ACTIVE_LOW, 0, 1 inverts the digit output (enabled = 0).
BCD_ONLY, 0, 1 blanks all segments for codes 10–15; 0 decodes the full hex set A–F.

Ports:
clk  input  1  system clock; all outputs update on the rising edge.
rst  input  1  synchronous, active-high reset.
w  input  1  code bit 3 (MSB).
x  input  1  code bit 2.
y  input  1  code bit 1.
z  input  1  code bit 0 (LSB).
a  output  1  segment a (top).
b  output  1  segment b (upper right).
c  output  1  segment c (lower right).
d  output  1  segment d (bottom).
e  output  1  segment e (lower left).
f  output  1  segment f (upper left).
g  output  1  segment g (middle).
dp  output  1  decimal point.
digit  output  1  digit enable.

Behaviour:
- Sampling: code = {w,x,y,z} is sampled on each rising clk edge. No input is used combinationally at the outputs.
- All outputs come from flops, so latency is exactly 1 cycle from code to outputs.
- Reset: when rst=1 at a rising edge, all segments a–g are unlit, dp is unlit and digit is disabled. These are logical values; polarity parameters apply to them.
- rst has priority over the code input.
- On the first edge with rst=0, the outputs reflect the code sampled at that edge and digit becomes enabled.
- Reset asserted mid-operation blanks the display at the next edge.
- Decode table, logical lit pattern in the order a b c d e f g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- BCD_ONLY=1: codes 10–15 produce all segments unlit, and digit stays enabled.
- dp: always logically unlit outside reset.
- digit: logically enabled whenever not in reset.
- Polarity: the physical output equals the logical value XOR the polarity parameter, applied before the output register. Outputs are therefore glitch-free.
- Input changes on every cycle must be tracked with no loss. There is no internal state other than the output registers.
- X or Z on an input is not required to be handled.

Test Plan:
- Reset: rst=1 for 2 cycles with code=8 -> a–g=0000000, dp=0, digit=0 (defaults). Release rst -> the next edge gives 1111111, dp=0, digit=1.
- Full sweep: cycle code through 0..15, one value per clock -> each output matches the table exactly one cycle later, e.g. 2 -> 1101101 and b -> 0011111.
- Binary-counter stimulus: toggle z/y/x/w at periods 1×/2×/4×/8× for 32 cycles -> the decode is correct on every cycle with 1-cycle lag and no missed value.
- Mid-run reset: code=5 running, assert rst for 1 cycle -> the next edge blanks the display (0000000, digit=0). Deassert -> 1011011 returns one edge later.
- BCD_ONLY=1: code=12 -> 0000000 with digit=1; code=9 -> 1111011.
- SEG_ACTIVE_LOW=1, DIGIT_ACTIVE_LOW=1: code=0 -> a–g=0000001, dp=1, digit=0. In reset -> a–g=1111111, dp=1, digit=1.
